// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage bundle widths, bundle structs, state enum.
// Imported by every pipeline stage register and its bench.
package pipe_pkg;

  localparam int IF_CTRL_W  = 1;
  localparam int IF_DATA_W  = 64;
  localparam int ID_CTRL_W  = 10;
  localparam int ID_DATA_W  = 136;
  localparam int EX_CTRL_W  = 3;
  localparam int EX_DATA_W  = 68;
  localparam int MEM_CTRL_W = 2;
  localparam int MEM_DATA_W = 68;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [3:0] exe_cmd;
    logic       b;
    logic       s;
    logic       imm;
  } id_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
  } id_data_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic pipe_state_e state_of(
    input logic main_v,
    input logic skid_v
  );
    if (skid_v) return FULL;
    if (main_v) return ONE;
    return EMPTY;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for per-stage performance events.
// Ports: clk, rst_n (async low), inc (count enable), cnt (value, sticks at all-ones).
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with 2-entry skid buffer and sync flush.
// Ports: clk, rst_n (async low), flush; in_valid/in_ready/in_ctrl/in_data
// upstream; out_valid/out_ready/out_ctrl/out_data downstream; with
// PIPE_STAGE_PERF_EN also stall_cnt and flush_cnt (saturating).
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_CTRL_W,
  parameter int DATA_W = ID_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic              main_v;
  logic              skid_v;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;
  logic              st_empty;
  logic              st_one;
  logic              st_full;
  pipe_state_e       state;

  if (CNT_W < 1 || CTRL_W < 1 || DATA_W < 1) begin : g_bad_param
    $error("pipe_stage_skid: widths must be positive");
  end

  // in_ready comes from a flop only: no path from out_ready.
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  assign st_empty = ~main_v;
  assign st_one   = main_v & ~skid_v;
  assign st_full  = skid_v;
  assign state    = state_of(main_v, skid_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      // Data is left stale; only ctrl must be clean for bubbles.
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      unique case (1'b1)
        st_empty: begin
          if (in_fire) begin
            main_v    <= 1'b1;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        st_one: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_v    <= 1'b1;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (out_fire) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
          end
        end
        st_full: begin
          if (out_fire) begin
            skid_v    <= 1'b0;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_ctrl <= '0;
          end
        end
        default: begin
          main_v <= main_v;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = out_valid & ~out_ready & ~flush;
  assign flush_inc = flush & main_v;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (flush_cnt)
  );
`endif

  a_bubble_ctrl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !out_valid |-> (out_ctrl == '0)
  );

  a_skid_main: assert property (
    @(posedge clk) disable iff (!rst_n)
    skid_v |-> main_v
  );

  a_state_ok: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == FULL) |-> !in_ready
  );

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed ID/EX pipeline register.
- Carries a control bundle and a data bundle between pipeline stages with valid/ready handshake, synchronous flush and a 2-entry skid buffer.
- Back-pressure is handled without a combinational ready path.
- Control bits are forced to zero on every bubble, so downstream never sees spurious WB/MEM enables.
- Instantiated at the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

Parameters:
- CTRL_W, 10, width of control bundle (enables, EXE_CMD, B, S, imm); zeroed on bubble/flush.
- DATA_W, 136, width of data bundle (pc, Val_Rn, Val_Rm, shift_operand, signed_imm_24, dest); not zeroed except at reset.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; kills all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept; registered, function of state only.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  out_ctrl/out_data valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control to next stage; all-zero whenever out_valid=0.
- out_data  out  DATA_W  data to next stage.
- stall_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN.
- flush_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - main_v=skid_v=0; main/skid ctrl and data all 0.
  - out_valid=0, out_ctrl=0, out_data=0, in_ready=1; counters 0.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State is encoded by (main_v, skid_v); in_ready = ~skid_v.
- EMPTY (0,0):
  - in_fire -> ONE, main <= in.
- ONE (1,0):
  - in_fire & out_fire -> ONE, main <= in.
  - in_fire & ~out_fire -> FULL, skid <= in.
  - ~in_fire & out_fire -> EMPTY, main_ctrl <= 0.
  - neither -> hold.
- FULL (1,1):
  - in_ready=0.
  - out_fire -> ONE, main <= skid, skid_ctrl <= 0.
  - otherwise hold.
- Latency and throughput: 1 cycle in->out from EMPTY; sustained 1 entry/cycle when out_ready=1.
- out_ctrl/out_data are driven straight from the main register.
- An entry is never duplicated or reordered.
- flush=1 at a clock edge:
  - Next state is EMPTY; main_ctrl=skid_ctrl=0; data registers hold.
  - Any in_fire or out_fire in that cycle is discarded; the entry counts as consumed.
- Flush has priority over every handshake; reset has priority over flush.
- Reset asserted mid-transfer: everything clears immediately; no entry survives.
- Invariants:
  - out_valid=0 implies out_ctrl=0.
  - skid_v=1 implies main_v=1.
  - in_ready does not depend combinationally on out_ready or in_valid.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & ~out_ready & ~flush.
  - flush_cnt increments each cycle flush=1 while main_v=1.
  - Both saturate at all-ones and clear only on reset.
- Undefined: stall_cnt/flush_cnt ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams ID_CTRL_W=10, ID_DATA_W=136, plus widths of the other stage bundles.
  - Enum pipe_state_e {EMPTY, ONE, FULL}, used for assertions and debug only.
- One sub-module: pipe_sat_counter (CNT_W, inc, saturating, async active-low reset), instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset/idle: rst_n=0 with in_valid=1 and in_ctrl=10'h3FF -> out_valid=0, out_ctrl=0, in_ready=1. After release with in_ctrl=10'h155, in_data=1 -> next cycle out_valid=1, out_ctrl=10'h155, out_data=1.
- Streaming: out_ready=1, send data 1..8 back-to-back -> out_data 1..8 on consecutive cycles, in_ready=1 throughout.
- Back-pressure:
  - Send A,B,C with out_ready=0 -> A held on output, B in skid, in_ready=0 after B, C not accepted.
  - Raise out_ready -> order A,B,C exactly, no loss.
- Flush in FULL: state FULL (A,B) with in_valid=1, flush=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1. Neither A nor B nor the flush-cycle input ever appears.
- Drain bubble: single entry ctrl=10'h3FF accepted, in_valid=0 -> after out_fire, out_valid=0 and out_ctrl=0.
- Perf (PIPE_STAGE_PERF_EN, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=4'hF, saturated. Then 3 flushes with main_v=1 -> flush_cnt=3.
